alu_ctrl_seq: RTL and testbench

Registered ALU-control stage for the MIPS ID/EX boundary: the next generation of the combinational ALU decoder. It decodes `i_aluop`/`i_opcode`/`i_funct` into a 5-bit ALU control code and registers it with a valid/ready handshake. It adds stall and flush handling and a multi-cycle sequencer for MULT/MULTU/DIV/DIVU that back-pressures the decode stage while the HI/LO unit is busy.

---
 rtl/alu_ctrl_seq.sv | 128 ++++++++++++
 tb/tb_alu_ctrl_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// Registered MIPS ALU-control stage with valid/ready handshake, stall/flush handling and a
// busy sequencer that back-pressures decode while the HI/LO unit runs MULT/MULTU/DIV/DIVU.
module alu_ctrl_seq #(
  parameter int unsigned SIZEOP     = 6,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNTW       = 6
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [1:0]        i_aluop,
  input  logic [SIZEOP-1:0] i_opcode,
  input  logic [SIZEOP-1:0] i_funct,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic              o_ready,
  output logic              o_valid,
  output logic [4:0]        o_alucontrol,
  output logic              o_md_start,
  output logic              o_md_busy,
  output logic              o_md_done
);

  localparam logic [4:0] CodeInv = 5'b01111;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e         state_q;
  logic [CNTW-1:0] cnt_q;
  logic           valid_q;
  logic [4:0]     code_q;
  logic           start_q;

  logic [4:0]     dec_code;
  logic           dec_md;
  logic           accept;

  always_comb begin
    dec_code = CodeInv;
    case (i_aluop)
      2'b00: dec_code = 5'b00110;
      2'b01: dec_code = CodeInv;
      2'b10: begin
        case (i_funct)
          6'b000000: dec_code = 5'b00000;
          6'b000010: dec_code = 5'b00001;
          6'b000011: dec_code = 5'b00010;
          6'b000100: dec_code = 5'b00011;
          6'b000110: dec_code = 5'b00100;
          6'b000111: dec_code = 5'b00101;
          6'b100001: dec_code = 5'b00110;
          6'b100011: dec_code = 5'b00111;
          6'b100101: dec_code = 5'b01000;
          6'b100110: dec_code = 5'b01001;
          6'b100100: dec_code = 5'b01010;
          6'b100111: dec_code = 5'b01011;
          6'b101010: dec_code = 5'b01100;
          6'b010000: dec_code = 5'b10100;
          6'b010010: dec_code = 5'b10101;
          6'b011000: dec_code = 5'b10000;
          6'b011001: dec_code = 5'b10001;
          6'b011010: dec_code = 5'b10010;
          6'b011011: dec_code = 5'b10011;
          default:   dec_code = CodeInv;
        endcase
      end
      default: begin
        case (i_opcode)
          6'b001000: dec_code = 5'b00110;
          6'b001100: dec_code = 5'b01010;
          6'b001101: dec_code = 5'b01000;
          6'b001110: dec_code = 5'b01001;
          6'b001111: dec_code = 5'b01101;
          6'b001010: dec_code = 5'b01100;
          default:   dec_code = CodeInv;
        endcase
      end
    endcase
  end

  // Codes 10000..10011 are the HI/LO multi-cycle ops; bit 1 selects divide.
  assign dec_md = (dec_code[4:2] == 3'b100);
  assign o_ready = (state_q == StIdle) && !i_stall && !i_flush;
  assign accept  = i_valid && o_ready;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= CodeInv;
      start_q <= 1'b0;
    end else if (i_flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      // The busy countdown runs regardless of stall.
      if (state_q == StBusy) begin
        if (cnt_q == '0) state_q <= StIdle;
        else             cnt_q   <= cnt_q - CNTW'(1);
      end
      if (!i_stall) begin
        if (accept) begin
          valid_q <= 1'b1;
          code_q  <= dec_code;
          start_q <= dec_md;
          if (dec_md) begin
            state_q <= StBusy;
            cnt_q   <= dec_code[1] ? CNTW'(DIV_CYCLES - 1) : CNTW'(MUL_CYCLES - 1);
          end
        end else begin
          valid_q <= 1'b0;
          start_q <= 1'b0;
        end
      end
    end
  end

  assign o_valid      = valid_q;
  assign o_alucontrol = code_q;
  assign o_md_start   = start_q;
  assign o_md_busy    = (state_q == StBusy);
  assign o_md_done    = (state_q == StBusy) && (cnt_q == '0);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decode table, directed multi-cycle sequences and
// randomized traffic against a remaining-cycles reference model.
module tb_alu_ctrl_seq;

  localparam int unsigned MulN = 4;
  localparam int unsigned DivN = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_valid, d_stall, d_flush;
  logic [1:0] d_aluop;
  logic [5:0] d_opcode, d_funct;
  logic       o_ready, o_valid, o_md_start, o_md_busy, o_md_done;
  logic [4:0] o_alucontrol;

  always #5 clk = ~clk;

  alu_ctrl_seq #(
    .SIZEOP(6), .MUL_CYCLES(MulN), .DIV_CYCLES(DivN), .CNTW(6)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_valid     (d_valid),
    .i_aluop     (d_aluop),
    .i_opcode    (d_opcode),
    .i_funct     (d_funct),
    .i_stall     (d_stall),
    .i_flush     (d_flush),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .o_alucontrol(o_alucontrol),
    .o_md_start  (o_md_start),
    .o_md_busy   (o_md_busy),
    .o_md_done   (o_md_done)
  );

  typedef struct {
    logic [1:0] aluop;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] code;
  } vec_t;

  vec_t vecs[$];

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state: m_left = busy cycles still to come, including the current one.
  logic       m_valid, m_start;
  logic [4:0] m_code;
  int         m_left;

  // Outputs sampled in the most recent step (the cycle before that step's edge).
  logic       s_ready, s_valid, s_start, s_busy, s_done;
  logic [4:0] s_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [4:0] ref_decode(input logic [1:0] a, input logic [5:0] op,
                                            input logic [5:0] fn);
    logic [4:0] r;
    r = 5'b01111;
    if (a == 2'b00) r = 5'b00110;
    else if (a != 2'b01) begin
      foreach (vecs[i]) begin
        if (vecs[i].aluop == a && ((a == 2'b11) ? (vecs[i].opcode == op) : (vecs[i].funct == fn)))
          r = vecs[i].code;
      end
    end
    return r;
  endfunction

  function automatic int md_cycles(input logic [4:0] c);
    if (c == 5'b10000 || c == 5'b10001) return MulN;
    if (c == 5'b10010 || c == 5'b10011) return DivN;
    return 0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_start = 1'b0;
    m_code  = 5'b01111;
    m_left  = 0;
  endtask

  task automatic step(input logic v, input logic [1:0] a, input logic [5:0] op,
                      input logic [5:0] fn, input logic st, input logic fl);
    int was;
    logic [4:0] c;
    @(negedge clk);
    d_valid = v; d_aluop = a; d_opcode = op; d_funct = fn; d_stall = st; d_flush = fl;
    #1;
    s_ready = o_ready; s_valid = o_valid; s_code = o_alucontrol;
    s_start = o_md_start; s_busy = o_md_busy; s_done = o_md_done;
    chk("ready", 32'(o_ready), 32'((m_left == 0) && !st && !fl));
    chk("valid", 32'(o_valid), 32'(m_valid));
    chk("code",  32'(o_alucontrol), 32'(m_code));
    chk("start", 32'(o_md_start), 32'(m_start));
    chk("busy",  32'(o_md_busy), 32'(m_left > 0));
    chk("done",  32'(o_md_done), 32'(m_left == 1));
    @(posedge clk);
    if (fl) begin
      m_valid = 1'b0; m_start = 1'b0; m_left = 0;
    end else begin
      was = m_left;
      if (m_left > 0) m_left--;
      if (!st) begin
        if (v && was == 0) begin
          c = ref_decode(a, op, fn);
          m_valid = 1'b1; m_code = c;
          m_start = (md_cycles(c) > 0);
          if (md_cycles(c) > 0) m_left = md_cycles(c);
        end else begin
          m_valid = 1'b0; m_start = 1'b0;
        end
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic rtype(input logic [5:0] fn);
    step(1'b1, 2'b10, 6'd0, fn, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while (m_left > 0 && guard < 100) begin idle(); guard++; end
    if (guard >= 100) chk("drain_timeout", 32'(m_left), 32'd0);
  endtask

  task automatic add_vec(input logic [1:0] a, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] c);
    vec_t e;
    e.aluop = a; e.opcode = op; e.funct = fn; e.code = c;
    vecs.push_back(e);
  endtask

  initial begin
    int lo_cnt, done_at, guard;
    vec_t e;

    add_vec(2'b00, 6'b100011, 6'b101010, 5'b00110);
    add_vec(2'b01, 6'b000100, 6'b100001, 5'b01111);
    add_vec(2'b11, 6'b001000, 6'd0, 5'b00110);
    add_vec(2'b11, 6'b001100, 6'd0, 5'b01010);
    add_vec(2'b11, 6'b001101, 6'd0, 5'b01000);
    add_vec(2'b11, 6'b001110, 6'd0, 5'b01001);
    add_vec(2'b11, 6'b001111, 6'd0, 5'b01101);
    add_vec(2'b11, 6'b001010, 6'd0, 5'b01100);
    add_vec(2'b11, 6'b111000, 6'd0, 5'b01111);
    add_vec(2'b11, 6'b111111, 6'd0, 5'b01111);
    add_vec(2'b10, 6'd0, 6'b000000, 5'b00000);
    add_vec(2'b10, 6'd0, 6'b000010, 5'b00001);
    add_vec(2'b10, 6'd0, 6'b000011, 5'b00010);
    add_vec(2'b10, 6'd0, 6'b000100, 5'b00011);
    add_vec(2'b10, 6'd0, 6'b000110, 5'b00100);
    add_vec(2'b10, 6'd0, 6'b000111, 5'b00101);
    add_vec(2'b10, 6'd0, 6'b100001, 5'b00110);
    add_vec(2'b10, 6'd0, 6'b100011, 5'b00111);
    add_vec(2'b10, 6'd0, 6'b100101, 5'b01000);
    add_vec(2'b10, 6'd0, 6'b100110, 5'b01001);
    add_vec(2'b10, 6'd0, 6'b100100, 5'b01010);
    add_vec(2'b10, 6'd0, 6'b100111, 5'b01011);
    add_vec(2'b10, 6'd0, 6'b101010, 5'b01100);
    add_vec(2'b10, 6'd0, 6'b010000, 5'b10100);
    add_vec(2'b10, 6'd0, 6'b010010, 5'b10101);
    add_vec(2'b10, 6'd0, 6'b011000, 5'b10000);
    add_vec(2'b10, 6'd0, 6'b011001, 5'b10001);
    add_vec(2'b10, 6'd0, 6'b011010, 5'b10010);
    add_vec(2'b10, 6'd0, 6'b011011, 5'b10011);
    add_vec(2'b10, 6'd0, 6'b111111, 5'b01111);

    rst_n = 1'b0;
    d_valid = 1'b0; d_aluop = 2'b00; d_opcode = '0; d_funct = '0; d_stall = 1'b0; d_flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset values.
    idle();
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_code",  32'(s_code), 32'h0f);
    chk("rst_ready", 32'(s_ready), 32'd1);

    // Single-cycle stream: ADDU, SUBU, ORI, LUI.
    rtype(6'b100001);
    rtype(6'b100011);
    chk("stream_addu", 32'(s_code), 32'h06);
    step(1'b1, 2'b11, 6'b001101, 6'd0, 1'b0, 1'b0);
    chk("stream_subu", 32'(s_code), 32'h07);
    step(1'b1, 2'b11, 6'b001111, 6'd0, 1'b0, 1'b0);
    chk("stream_ori", 32'(s_code), 32'h08);
    idle();
    chk("stream_lui", 32'(s_code), 32'h0d);
    chk("stream_valid", 32'(s_valid), 32'd1);

    // Decode table.
    foreach (vecs[i]) begin
      e = vecs[i];
      step(1'b1, e.aluop, e.opcode, e.funct, 1'b0, 1'b0);
      idle();
      chk("tbl_code",  32'(s_code), 32'(e.code));
      chk("tbl_valid", 32'(s_valid), 32'd1);
      chk("tbl_start", 32'(s_start), 32'(e.code[4:2] == 3'b100));
      drain();
    end

    // MULT window with a queued ADDU.
    rtype(6'b011000);
    lo_cnt = 0; done_at = 0; guard = 0;
    rtype(6'b100001);
    chk("mult_start", 32'(s_start), 32'd1);
    chk("mult_code",  32'(s_code), 32'h10);
    while (!s_ready && guard < 50) begin
      lo_cnt++;
      if (s_done) done_at = lo_cnt;
      rtype(6'b100001);
      guard++;
    end
    chk("mult_ready_low", 32'(lo_cnt), 32'(MulN));
    chk("mult_done_at",   32'(done_at), 32'(MulN));
    idle();
    chk("mult_queued_addu", 32'(s_code), 32'h06);
    chk("mult_queued_valid", 32'(s_valid), 32'd1);

    // Stall holds AND for 3 cycles.
    rtype(6'b100100);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 2'b10, 6'd0, 6'b100001, 1'b1, 1'b0);
      chk("stall_valid", 32'(s_valid), 32'd1);
      chk("stall_code",  32'(s_code), 32'h0a);
      chk("stall_ready", 32'(s_ready), 32'd0);
    end
    idle();
    chk("stall_after_code", 32'(s_code), 32'h0a);

    // Flush during DIV at busy cycle 10.
    rtype(6'b011010);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 2'b00, 6'd0, 6'd0, 1'b0, (k == 10));
      chk("div_busy", 32'(s_busy), 32'd1);
      chk("div_nodone", 32'(s_done), 32'd0);
    end
    idle();
    chk("flush_busy",  32'(s_busy), 32'd0);
    chk("flush_done",  32'(s_done), 32'd0);
    chk("flush_ready", 32'(s_ready), 32'd1);
    chk("flush_valid", 32'(s_valid), 32'd0);

    // Asynchronous reset mid-DIV.
    rtype(6'b011011);
    repeat (5) idle();
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_code",  32'(o_alucontrol), 32'h0f);
    chk("arst_start", 32'(o_md_start), 32'd0);
    chk("arst_busy",  32'(o_md_busy), 32'd0);
    chk("arst_done",  32'(o_md_done), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("arst_ready", 32'(s_ready), 32'd1);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      logic v, st, fl;
      logic [1:0] a;
      logic [5:0] op, fn;
      v  = ($urandom_range(0, 9) < 7);
      st = ($urandom_range(0, 99) < 15);
      fl = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 1) == 0) begin
        e = vecs[$urandom_range(0, vecs.size() - 1)];
        a = e.aluop; op = e.opcode; fn = e.funct;
      end else begin
        a = 2'($urandom); op = 6'($urandom); fn = 6'($urandom);
      end
      step(v, a, op, fn, st, fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
